led_ring_checker: RTL and testbench



---
 rtl/led_ring_checker_if.sv | 30 +++
 rtl/led_ring_checker.sv | 157 +++++++++++++++
 tb/tb_led_ring_checker.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_ring_checker_if.sv
// Bundles the LED step strobe, the observed pattern and the checker status outputs.
// The checker connects through the slave modport; the stimulus side uses master.
interface led_ring_checker_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 2,
    parameter int REV_W = 8,
    parameter int ERR_W = 4
) ();
    logic             en;
    logic [WIDTH-1:0] led_in;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             locked;
    logic             step_err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;
    logic [REV_W-1:0] rev_cnt;
    logic             rev_pulse;

    modport master (
        output en, led_in, clr,
        input  pos, pos_valid, locked, step_err, err_sticky, err_cnt, rev_cnt, rev_pulse
    );

    modport slave (
        input  en, led_in, clr,
        output pos, pos_valid, locked, step_err, err_sticky, err_cnt, rev_cnt, rev_pulse
    );
endinterface

// File: rtl/led_ring_checker.sv
// Receive-side checker for a rotating one-hot LED pattern: hunts for a one-hot value,
// locks after LOCK_CNT legal rotate-left steps, then counts revolutions and illegal steps.
module led_ring_checker #(
    parameter int WIDTH    = 4,
    parameter int POS_W    = 2,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    led_ring_checker_if.slave   bus
);

    localparam int SYNC_W = $clog2(LOCK_CNT + 1);
    localparam logic [SYNC_W-1:0] LOCK_CNT_V = SYNC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   prev_q;
    logic [SYNC_W-1:0]  sync_cnt_q;
    logic [POS_W-1:0]   pos_q;
    logic               pos_valid_q;
    logic               locked_q;
    logic               step_err_q;
    logic               err_sticky_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [REV_W-1:0]   rev_cnt_q;
    logic               rev_pulse_q;

    logic [WIDTH-1:0]   led;
    logic               led_onehot;
    logic [WIDTH-1:0]   prev_succ;
    logic               led_is_succ;
    logic               prev_wraps;
    logic [POS_W-1:0]   led_idx;
    logic [POS_W-1:0]   idx_term [WIDTH];
    logic [SYNC_W-1:0]  sync_cnt_d;
    logic [ERR_W-1:0]   err_cnt_d;
    logic [REV_W-1:0]   rev_cnt_d;

    assign led        = bus.led_in;
    // x & (x-1) clears the lowest set bit, so zero result on a nonzero x means one-hot
    assign led_onehot = (led != '0) && ((led & (led - WIDTH'(1))) == '0);
    assign prev_succ  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign led_is_succ = led_onehot && (led == prev_succ);
    assign prev_wraps = prev_q[WIDTH-1];

    // Per-bit index contributions; only one is nonzero when the input is one-hot
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_idx
            assign idx_term[gi] = led[gi] ? POS_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        led_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            led_idx = led_idx | idx_term[i];
        end
    end

    assign sync_cnt_d = sync_cnt_q + SYNC_W'(1);
    assign err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    assign rev_cnt_d  = rev_cnt_q + REV_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            sync_cnt_q   <= '0;
            pos_q        <= '0;
            pos_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            rev_cnt_q    <= '0;
            rev_pulse_q  <= 1'b0;
        end else begin
            step_err_q  <= 1'b0;
            rev_pulse_q <= 1'b0;
            if (bus.en) begin
                pos_valid_q <= led_onehot;
                if (led_onehot) begin
                    pos_q <= led_idx;
                end
                case (state_q)
                    HUNT: begin
                        if (led_onehot) begin
                            prev_q     <= led;
                            sync_cnt_q <= '0;
                            state_q    <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (led_is_succ) begin
                            prev_q     <= led;
                            sync_cnt_q <= sync_cnt_d;
                            if (sync_cnt_d == LOCK_CNT_V) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else if (led_onehot) begin
                            // A fresh one-hot value restarts the lock run from itself
                            prev_q     <= led;
                            sync_cnt_q <= '0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (led_is_succ) begin
                            prev_q <= led;
                            if (prev_wraps) begin
                                rev_cnt_q   <= rev_cnt_d;
                                rev_pulse_q <= 1'b1;
                            end
                        end else begin
                            step_err_q   <= 1'b1;
                            err_sticky_q <= 1'b1;
                            err_cnt_q    <= err_cnt_d;
                            prev_q       <= '0;
                            state_q      <= HUNT;
                            locked_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any same-cycle increment or sticky set
            if (bus.clr) begin
                rev_cnt_q    <= '0;
                err_cnt_q    <= '0;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.pos        = pos_q;
    assign bus.pos_valid  = pos_valid_q;
    assign bus.locked     = locked_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.rev_cnt    = rev_cnt_q;
    assign bus.rev_pulse  = rev_pulse_q;

endmodule

// File: tb/tb_led_ring_checker.sv
// Scoreboard bench for led_ring_checker: a reference model queues expected outputs per step
// and they are compared one cycle later, alongside directed checks of key scenarios.
module tb_led_ring_checker;

    localparam int WIDTH    = 4;
    localparam int POS_W    = 2;
    localparam int LOCK_CNT = 2;
    localparam int REV_W    = 8;
    localparam int ERR_W    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    led_ring_checker_if #(.WIDTH(WIDTH), .POS_W(POS_W), .REV_W(REV_W), .ERR_W(ERR_W)) bus ();

    led_ring_checker #(
        .WIDTH(WIDTH), .POS_W(POS_W), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] pos;
        logic       pos_valid;
        logic       locked;
        logic       step_err;
        logic       err_sticky;
        logic [3:0] err_cnt;
        logic [7:0] rev_cnt;
        logic       rev_pulse;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    int         m_state;   // 0 hunt, 1 sync, 2 locked
    logic [3:0] m_prev;
    int         m_cnt;
    exp_t       m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m       = '0;
        m_state = 0;
        m_prev  = 4'b0000;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic en, input logic [3:0] led, input logic clr);
        logic       oh;
        logic [3:0] nxt;
        m.step_err  = 1'b0;
        m.rev_pulse = 1'b0;
        if (en) begin
            oh = ($countones(led) == 1);
            m.pos_valid = oh;
            if (oh) begin
                for (int i = 0; i < 4; i++) if (led[i]) m.pos = 2'(i);
            end
            nxt = {m_prev[2:0], m_prev[3]};
            case (m_state)
                0: if (oh) begin m_prev = led; m_cnt = 0; m_state = 1; end
                1: begin
                    if (oh && led == nxt) begin
                        m_prev = led;
                        m_cnt++;
                        if (m_cnt == LOCK_CNT) m_state = 2;
                    end else if (oh) begin
                        m_prev = led;
                        m_cnt  = 0;
                    end else begin
                        m_state = 0;
                    end
                end
                default: begin
                    if (oh && led == nxt) begin
                        if (m_prev[3]) begin
                            m.rev_cnt   = m.rev_cnt + 8'd1;
                            m.rev_pulse = 1'b1;
                        end
                        m_prev = led;
                    end else begin
                        m.step_err   = 1'b1;
                        m.err_sticky = 1'b1;
                        if (m.err_cnt != 4'hF) m.err_cnt = m.err_cnt + 4'd1;
                        m_prev  = 4'b0000;
                        m_state = 0;
                    end
                end
            endcase
            m.locked = (m_state == 2);
        end
        if (clr) begin
            m.rev_cnt    = 8'd0;
            m.err_cnt    = 4'd0;
            m.err_sticky = 1'b0;
        end
    endtask

    task automatic compare_out(input logic en, input logic [3:0] led, input logic clr);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no queued entry expected one");
        end else begin
            e = sb_q.pop_front();
            chk("pos",        32'(bus.pos),        32'(e.pos));
            chk("pos_valid",  32'(bus.pos_valid),  32'(e.pos_valid));
            chk("locked",     32'(bus.locked),     32'(e.locked));
            chk("step_err",   32'(bus.step_err),   32'(e.step_err));
            chk("err_sticky", 32'(bus.err_sticky), 32'(e.err_sticky));
            chk("err_cnt",    32'(bus.err_cnt),    32'(e.err_cnt));
            chk("rev_cnt",    32'(bus.rev_cnt),    32'(e.rev_cnt));
            chk("rev_pulse",  32'(bus.rev_pulse),  32'(e.rev_pulse));
        end
        $display("[%0t] en=%b led=%b clr=%b -> pos=%0d pv=%b lk=%b se=%b st=%b ec=%0d rc=%0d rp=%b",
                 $time, en, led, clr, bus.pos, bus.pos_valid, bus.locked, bus.step_err,
                 bus.err_sticky, bus.err_cnt, bus.rev_cnt, bus.rev_pulse);
    endtask

    task automatic step(input logic en, input logic [3:0] led, input logic clr);
        @(negedge clk);
        bus.en     = en;
        bus.led_in = led;
        bus.clr    = clr;
        model_step(en, led, clr);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        compare_out(en, led, clr);
    endtask

    task automatic relock();
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_pos"},        32'(bus.pos),        32'd0);
        chk({pfx, "_pos_valid"},  32'(bus.pos_valid),  32'd0);
        chk({pfx, "_locked"},     32'(bus.locked),     32'd0);
        chk({pfx, "_step_err"},   32'(bus.step_err),   32'd0);
        chk({pfx, "_err_sticky"}, 32'(bus.err_sticky), 32'd0);
        chk({pfx, "_err_cnt"},    32'(bus.err_cnt),    32'd0);
        chk({pfx, "_rev_cnt"},    32'(bus.rev_cnt),    32'd0);
        chk({pfx, "_rev_pulse"},  32'(bus.rev_pulse),  32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.en = 1'b0;
        #2 reset = 1'b0;
        #1 chk_all_zero("areset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] last_led;
        logic [3:0] rnd_led;
        bus.en     = 1'b0;
        bus.led_in = 4'b0000;
        bus.clr    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_all_zero("init");
        @(negedge clk);
        reset = 1'b1;

        // Clean ring: lock on the third sample, revolution on the fifth
        step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        chk("lock_after_3", 32'(bus.locked), 32'd1);
        step(1'b1, 4'b1000, 1'b0);
        chk("pos_3", 32'(bus.pos), 32'd3);
        step(1'b1, 4'b0001, 1'b0);
        chk("rev_pulse_5", 32'(bus.rev_pulse), 32'd1);
        chk("rev_cnt_5",   32'(bus.rev_cnt),   32'd1);
        chk("pos_wrap_0",  32'(bus.pos),       32'd0);

        // Skip while locked, then relock
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        chk("skip_step_err", 32'(bus.step_err),   32'd1);
        chk("skip_err_cnt",  32'(bus.err_cnt),    32'd1);
        chk("skip_sticky",   32'(bus.err_sticky), 32'd1);
        chk("skip_unlock",   32'(bus.locked),     32'd0);
        relock();
        chk("relock", 32'(bus.locked), 32'd1);
        step(1'b0, 4'b0000, 1'b0);
        chk("no_more_err", 32'(bus.err_cnt), 32'd1);

        // Mid-stream asynchronous reset
        apply_reset();

        // Illegal values in hunt, then in locked
        step(1'b1, 4'b0000, 1'b0);
        chk("hunt_zero_pv", 32'(bus.pos_valid), 32'd0);
        step(1'b1, 4'b0011, 1'b0);
        chk("hunt_multi_pv",  32'(bus.pos_valid), 32'd0);
        chk("hunt_multi_err", 32'(bus.err_cnt),   32'd0);
        relock();
        step(1'b1, 4'b0000, 1'b0);
        chk("lock_zero_err", 32'(bus.err_cnt), 32'd1);
        relock();
        step(1'b1, 4'b0011, 1'b0);
        chk("lock_multi_err", 32'(bus.err_cnt), 32'd2);

        // Saturation, then clear racing a same-cycle error
        step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 17; i++) begin
            relock();
            step(1'b1, 4'b0000, 1'b0);
        end
        chk("err_sat", 32'(bus.err_cnt), 32'd15);
        relock();
        step(1'b1, 4'b0010, 1'b1);
        chk("clr_err_cnt",  32'(bus.err_cnt),    32'd0);
        chk("clr_sticky",   32'(bus.err_sticky), 32'd0);
        chk("clr_step_err", 32'(bus.step_err),   32'd1);

        // Revolutions with en gaps early on, running the counter through its wrap
        step(1'b0, 4'b0000, 1'b1);
        relock();
        for (int r = 0; r < 256; r++) begin
            if (r < 3) repeat (5) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            step(1'b1, 4'b1000, 1'b0);
            if (r < 3) repeat (5) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
            step(1'b1, 4'b0001, 1'b0);
            chk("rev_count", 32'(bus.rev_cnt), 32'((r + 1) % 256));
            step(1'b1, 4'b0010, 1'b0);
            step(1'b1, 4'b0100, 1'b0);
        end
        step(1'b1, 4'b1000, 1'b0);
        chk("gap_no_err", 32'(bus.err_cnt), 32'd0);

        // Mixed traffic: mostly legal successors, some junk, occasional clears
        last_led = 4'b1000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_led = {last_led[2:0], last_led[3]};
            else                           rnd_led = 4'($urandom_range(0, 15));
            if (rnd_led == 4'b0000 && $urandom_range(0, 1) == 1) rnd_led = 4'b0001;
            step(($urandom_range(0, 4) != 0), rnd_led, ($urandom_range(0, 19) == 0));
            if (bus.en) last_led = rnd_led;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
